// File: rtl/fp_issue_ctrl_if.sv
// ============================================================================
// Module   : fp_issue_ctrl_if
// Function : FP issue controller handshake and decoded-control bundle
// Revision : 1.0
// ============================================================================
`default_nettype none

interface fp_issue_ctrl_if;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic [2:0]  fp_alu_ctrl;
  logic        fp_alu_src;
  logic        fp_reg_dst;
  logic [4:0]  Rs;
  logic [4:0]  Rt;
  logic [4:0]  Rd;
  logic [15:0] immediate;
  logic        fp_write_en;
  logic        busy;
  logic        illegal;
  logic [7:0]  retired;

  modport master (
    output instr_valid, instr,
    input  instr_ready, fp_alu_ctrl, fp_alu_src, fp_reg_dst, Rs, Rt, Rd,
           immediate, fp_write_en, busy, illegal, retired
  );

  modport slave (
    input  instr_valid, instr,
    output instr_ready, fp_alu_ctrl, fp_alu_src, fp_reg_dst, Rs, Rt, Rd,
           immediate, fp_write_en, busy, illegal, retired
  );
endinterface

`default_nettype wire

// File: rtl/fp_issue_ctrl.sv
// ============================================================================
// Module   : fp_issue_ctrl
// Function : single-issue FP decode/issue controller with per-op latency
// Revision : 1.0
// ============================================================================
`default_nettype none

module fp_issue_ctrl #(
  parameter int LAT_ADDSUB = 3,
  parameter int LAT_MUL    = 4,
  parameter int LAT_DIV    = 10,
  parameter int LAT_SQRT   = 16,
  parameter int LAT_CVT    = 2
) (
  input  logic          cpu_clk,
  input  logic          reset,
  fp_issue_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EXEC  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  // Counter preloads are latency-1 so EXEC lasts exactly LAT cycles.
  localparam logic [4:0] c_lat_addsub_m1 = 5'(LAT_ADDSUB - 1);
  localparam logic [4:0] c_lat_mul_m1    = 5'(LAT_MUL - 1);
  localparam logic [4:0] c_lat_div_m1    = 5'(LAT_DIV - 1);
  localparam logic [4:0] c_lat_sqrt_m1   = 5'(LAT_SQRT - 1);
  localparam logic [4:0] c_lat_cvt_m1    = 5'(LAT_CVT - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [4:0]  r_cnt;
  logic [4:0]  w_cnt_nxt;

  logic        w_accept;
  logic        w_legal;
  logic [2:0]  w_ctrl;
  logic        w_src;
  logic        w_dst;
  logic [4:0]  w_lat_m1;

  logic [2:0]  r_ctrl;
  logic        r_src;
  logic        r_dst;
  logic [4:0]  r_rs;
  logic [4:0]  r_rt;
  logic [4:0]  r_rd;
  logic [15:0] r_imm;
  logic        r_ill;
  logic [7:0]  r_retired;

  assign w_accept = bus.instr_valid && (r_state == S_IDLE);

  always_comb begin
    w_legal  = 1'b0;
    w_ctrl   = 3'b000;
    w_src    = 1'b0;
    w_dst    = 1'b1;
    w_lat_m1 = 5'd0;
    case (bus.instr[31:26])
      6'h11: begin
        w_legal = 1'b1;
        case (bus.instr[5:0])
          6'h00:   begin w_ctrl = 3'b000; w_lat_m1 = c_lat_addsub_m1; end
          6'h01:   begin w_ctrl = 3'b001; w_lat_m1 = c_lat_addsub_m1; end
          6'h02:   begin w_ctrl = 3'b010; w_lat_m1 = c_lat_mul_m1;    end
          6'h03:   begin w_ctrl = 3'b011; w_lat_m1 = c_lat_div_m1;    end
          6'h04:   begin w_ctrl = 3'b100; w_lat_m1 = c_lat_sqrt_m1;   end
          6'h24:   begin w_ctrl = 3'b101; w_lat_m1 = c_lat_cvt_m1;    end
          default: w_legal = 1'b0;
        endcase
      end
      6'h12: begin
        w_legal  = 1'b1;
        w_src    = 1'b1;
        w_dst    = 1'b0;
        w_lat_m1 = c_lat_addsub_m1;
      end
      default: w_legal = 1'b0;
    endcase
  end

  always_ff @(posedge cpu_clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 5'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_accept && w_legal) begin
          w_state_nxt = S_EXEC;
          w_cnt_nxt   = w_lat_m1;
        end
      end
      S_EXEC: begin
        if (r_cnt == 5'd0) w_state_nxt = S_WRITE;
        else               w_cnt_nxt   = r_cnt - 5'd1;
      end
      S_WRITE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Decoded fields only change on a legal accept; illegal words leave them intact.
  always_ff @(posedge cpu_clk) begin
    if (reset) begin
      r_ctrl    <= 3'b000;
      r_src     <= 1'b0;
      r_dst     <= 1'b0;
      r_rs      <= 5'd0;
      r_rt      <= 5'd0;
      r_rd      <= 5'd0;
      r_imm     <= 16'd0;
      r_ill     <= 1'b0;
      r_retired <= 8'd0;
    end else begin
      r_ill <= w_accept && !w_legal;
      if (w_accept && w_legal) begin
        r_ctrl <= w_ctrl;
        r_src  <= w_src;
        r_dst  <= w_dst;
        r_rs   <= bus.instr[25:21];
        r_rt   <= bus.instr[20:16];
        r_rd   <= bus.instr[15:11];
        r_imm  <= bus.instr[15:0];
      end
      if (r_state == S_WRITE) r_retired <= r_retired + 8'd1;
    end
  end

  assign bus.instr_ready = (r_state == S_IDLE);
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.fp_write_en = (r_state == S_WRITE);
  assign bus.illegal     = r_ill;
  assign bus.retired     = r_retired;
  assign bus.fp_alu_ctrl = r_ctrl;
  assign bus.fp_alu_src  = r_src;
  assign bus.fp_reg_dst  = r_dst;
  assign bus.Rs          = r_rs;
  assign bus.Rt          = r_rt;
  assign bus.Rd          = r_rd;
  assign bus.immediate   = r_imm;

endmodule

`default_nettype wire

// File: tb/tb_fp_issue_ctrl.sv
// ============================================================================
// Module   : tb_fp_issue_ctrl
// Function : directed + random bench against a transaction-timeline model
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fp_issue_ctrl;

  localparam int LAT_ADDSUB = 3;
  localparam int LAT_MUL    = 4;
  localparam int LAT_DIV    = 10;
  localparam int LAT_SQRT   = 16;
  localparam int LAT_CVT    = 2;

  logic cpu_clk;
  logic reset;
  fp_issue_ctrl_if bus();

  fp_issue_ctrl #(
    .LAT_ADDSUB(LAT_ADDSUB), .LAT_MUL(LAT_MUL), .LAT_DIV(LAT_DIV),
    .LAT_SQRT(LAT_SQRT), .LAT_CVT(LAT_CVT)
  ) dut (
    .cpu_clk(cpu_clk),
    .reset  (reset),
    .bus    (bus)
  );

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Model: phase = cycles since the accept edge (-1 when idle).
  int          m_phase   = -1;
  int          m_lat     = 0;
  int          m_accepts = 0;
  bit          m_accepted;
  logic        m_ill     = 1'b0;
  logic [7:0]  m_retired = 8'd0;
  logic [2:0]  m_ctrl    = 3'd0;
  logic        m_src     = 1'b0;
  logic        m_dst     = 1'b0;
  logic [4:0]  m_rs      = 5'd0;
  logic [4:0]  m_rt      = 5'd0;
  logic [4:0]  m_rd      = 5'd0;
  logic [15:0] m_imm     = 16'd0;

  logic [5:0] funct_tab [6] = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h24};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic bit ref_decode(input logic [31:0] ins, output int lat,
                                    output logic [2:0] ctrl, output logic src,
                                    output logic dst);
    lat = 0; ctrl = 3'd0; src = 1'b0; dst = 1'b1;
    if (ins[31:26] == 6'h12) begin
      src = 1'b1; dst = 1'b0; lat = LAT_ADDSUB;
      return 1'b1;
    end
    if (ins[31:26] != 6'h11) return 1'b0;
    case (ins[5:0])
      6'h00: begin ctrl = 3'b000; lat = LAT_ADDSUB; end
      6'h01: begin ctrl = 3'b001; lat = LAT_ADDSUB; end
      6'h02: begin ctrl = 3'b010; lat = LAT_MUL;    end
      6'h03: begin ctrl = 3'b011; lat = LAT_DIV;    end
      6'h04: begin ctrl = 3'b100; lat = LAT_SQRT;   end
      6'h24: begin ctrl = 3'b101; lat = LAT_CVT;    end
      default: return 1'b0;
    endcase
    return 1'b1;
  endfunction

  task automatic model_edge(input bit rst_v, input bit vld, input logic [31:0] ins);
    int lat; logic [2:0] ctrl; logic src; logic dst;
    m_ill = 1'b0;
    m_accepted = 1'b0;
    if (rst_v) begin
      m_phase = -1; m_retired = 8'd0; m_ctrl = 3'd0; m_src = 1'b0; m_dst = 1'b0;
      m_rs = 5'd0; m_rt = 5'd0; m_rd = 5'd0; m_imm = 16'd0;
    end else if (m_phase >= 0) begin
      m_phase++;
      if (m_phase == m_lat + 2) begin
        m_phase = -1;
        m_retired = m_retired + 8'd1;
      end
    end else if (vld) begin
      if (ref_decode(ins, lat, ctrl, src, dst)) begin
        m_phase = 1; m_lat = lat; m_ctrl = ctrl; m_src = src; m_dst = dst;
        m_rs = ins[25:21]; m_rt = ins[20:16]; m_rd = ins[15:11]; m_imm = ins[15:0];
        m_accepted = 1'b1;
        m_accepts++;
      end else begin
        m_ill = 1'b1;
      end
    end
  endtask

  task automatic check_all();
    check_eq("instr_ready", bus.instr_ready, m_phase < 0);
    check_eq("busy",        bus.busy,        m_phase >= 1);
    check_eq("fp_write_en", bus.fp_write_en, m_phase == m_lat + 1);
    check_eq("illegal",     bus.illegal,     m_ill);
    check_eq("retired",     bus.retired,     m_retired);
    check_eq("fp_alu_ctrl", bus.fp_alu_ctrl, m_ctrl);
    check_eq("fp_alu_src",  bus.fp_alu_src,  m_src);
    check_eq("fp_reg_dst",  bus.fp_reg_dst,  m_dst);
    check_eq("Rs",          bus.Rs,          m_rs);
    check_eq("Rt",          bus.Rt,          m_rt);
    check_eq("Rd",          bus.Rd,          m_rd);
    check_eq("immediate",   bus.immediate,   m_imm);
  endtask

  // Called at a falling edge: drive, clock once, update model, sample.
  task automatic tick(input bit rst_v, input bit vld, input logic [31:0] ins);
    reset = rst_v;
    bus.instr_valid = vld;
    bus.instr = ins;
    @(posedge cpu_clk);
    model_edge(rst_v, vld, ins);
    cyc++;
    @(negedge cpu_clk);
    check_all();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 9))
      0, 1, 2, 3, 4, 5: begin w[31:26] = 6'h11; w[5:0] = funct_tab[$urandom_range(0, 5)]; end
      6, 7:             w[31:26] = 6'h12;
      8:                begin w[31:26] = 6'h11; w[5:0] = 6'h3E; end
      default:          ;
    endcase
    return w;
  endfunction

  initial begin
    int n;
    int last_acc;
    reset = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instr = 32'd0;
    @(negedge cpu_clk);

    repeat (2) tick(1'b1, 1'b0, 32'd0);

    // mul: 4 EXEC + 1 WRITE, then one retirement
    tick(1'b0, 1'b1, 32'h44430802);
    check_eq("mul_ctrl", bus.fp_alu_ctrl, 3'b010);
    check_eq("mul_rs",   bus.Rs, 5'd2);
    check_eq("mul_rt",   bus.Rt, 5'd3);
    check_eq("mul_rd",   bus.Rd, 5'd1);
    repeat (4) tick(1'b0, 1'b0, 32'd0);
    check_eq("mul_wen_c5", bus.fp_write_en, 1'b1);
    tick(1'b0, 1'b0, 32'd0);
    check_eq("mul_retired", bus.retired, 8'd1);

    // add-immediate
    tick(1'b0, 1'b1, 32'h48A53F80);
    check_eq("addi_src", bus.fp_alu_src, 1'b1);
    check_eq("addi_imm", bus.immediate, 16'h3F80);
    repeat (3) tick(1'b0, 1'b0, 32'd0);
    check_eq("addi_wen_c4", bus.fp_write_en, 1'b1);
    tick(1'b0, 1'b0, 32'd0);

    // sqrt with a competing instruction held valid
    tick(1'b0, 1'b1, 32'h44000004);
    n = 1;
    while (!bus.instr_ready && n < 40) begin
      tick(1'b0, 1'b1, 32'h44221800);
      n++;
    end
    check_eq("sqrt_ready_after", n, 18);
    tick(1'b0, 1'b1, 32'h44221800);
    check_eq("second_accepted", bus.fp_alu_ctrl, 3'b000);
    repeat (5) tick(1'b0, 1'b0, 32'd0);

    // illegal opcode
    tick(1'b0, 1'b1, 32'hFC00FFFF);
    check_eq("ill_pulse", bus.illegal, 1'b1);
    tick(1'b0, 1'b0, 32'd0);
    check_eq("ill_gone", bus.illegal, 1'b0);

    // div aborted by reset in its 4th EXEC cycle
    tick(1'b0, 1'b1, 32'h44000003);
    repeat (3) tick(1'b0, 1'b0, 32'd0);
    tick(1'b1, 1'b0, 32'd0);
    check_eq("abort_busy", bus.busy, 1'b0);
    check_eq("abort_retired", bus.retired, 8'd0);
    repeat (12) tick(1'b0, 1'b0, 32'd0);

    // 256 back-to-back cvt
    m_accepts = 0;
    last_acc = -1;
    n = 0;
    while (m_accepts < 256 && n < 256 * 4 + 20) begin
      tick(1'b0, 1'b1, 32'h44000024);
      if (m_accepted) begin
        if (last_acc >= 0) check_eq("cvt_spacing", cyc - last_acc, 4);
        last_acc = cyc;
      end
      n++;
    end
    check_eq("cvt_count", m_accepts, 256);
    repeat (4) tick(1'b0, 1'b0, 32'd0);
    check_eq("cvt_wrap", bus.retired, 8'd0);

    // randomized traffic with occasional reset
    repeat (600) tick($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0, rand_instr());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
